load_store_unit: RTL and testbench

//  Single-entry load/store execution unit sitting directly upstream of D_cache.

---
 rtl/load_store_unit_if.sv | 59 +++++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// load_store_unit_if
// Bundles every signal of the load/store unit except clk/rst: the issue
// handshake, the D_cache request/response pair, the CDB broadcast, the flush
// and a debug view of the FSM state.
//   slave  : the load/store unit itself
//   master : the environment (issue stage, D_cache, CDB arbiter, testbench)
//
// Handshake semantics:
//   - Issue: an op transfers on a rising edge where ls_valid && ls_ready.
//     ls_ready is high only while the unit is idle.
//   - D_cache: cache_read/cache_write is a request that stays asserted, with
//     address, data and size held constant, until an edge with
//     cache2proc_valid. That edge completes the access. Read and write are
//     never asserted together.
//   - CDB: cdb_valid stays high and cdb_tag/cdb_value/cdb_exc stay constant
//     until an edge with cdb_grant. That edge retires the result.
// ----------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             ls_valid;
    logic             ls_ready;
    logic             ls_is_store;
    logic [XLEN-1:0]  ls_base;
    logic [XLEN-1:0]  ls_offset;
    logic [XLEN-1:0]  ls_store_data;
    logic [2:0]       ls_size;
    logic [TAG_W-1:0] ls_tag;
    logic             cache_read;
    logic             cache_write;
    logic [XLEN-1:0]  proc2cache_addr;
    logic [XLEN-1:0]  proc2cache_data;
    logic [2:0]       proc2cache_size;
    logic [XLEN-1:0]  cache2proc_data;
    logic             cache2proc_valid;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_value;
    logic             cdb_exc;
    logic             cdb_grant;
    logic [1:0]       state_dbg;

    modport slave (
        input  flush, ls_valid, ls_is_store, ls_base, ls_offset, ls_store_data,
               ls_size, ls_tag, cache2proc_data, cache2proc_valid, cdb_grant,
        output ls_ready, cache_read, cache_write, proc2cache_addr, proc2cache_data,
               proc2cache_size, cdb_valid, cdb_tag, cdb_value, cdb_exc, state_dbg
    );

    modport master (
        output flush, ls_valid, ls_is_store, ls_base, ls_offset, ls_store_data,
               ls_size, ls_tag, cache2proc_data, cache2proc_valid, cdb_grant,
        input  ls_ready, cache_read, cache_write, proc2cache_addr, proc2cache_data,
               proc2cache_size, cdb_valid, cdb_tag, cdb_value, cdb_exc, state_dbg
    );
endinterface

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Single-entry load/store execution unit in front of a word-only D_cache.
// It accepts one op from issue and computes the effective address. It then
// runs the cache access and broadcasts the result on the CDB. Byte and half
// loads are extracted and extended here. Byte and half stores do a
// read-modify-write of the containing word.
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset
//   bus  - load_store_unit_if.slave (issue, D_cache, CDB, flush, state_dbg)
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    load_store_unit_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  data_q;      // store data, replaced by the merged word after RD
    logic [XLEN-1:0]  word_q;      // word returned by the cache for loads / RMW
    logic [2:0]       size_q;
    logic             is_store_q;
    logic [TAG_W-1:0] tag_q;
    logic             exc_q;

    logic [XLEN-1:0]  addr_d;
    logic             misaligned_d;

    // Lane from the low address bits, then sign or zero extension (size[2] = unsigned).
    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] w,
                                                     input logic [1:0]      off,
                                                     input logic [2:0]      sz);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (sz[1:0])
            2'b00:   return sz[2] ? {{(XLEN-8){1'b0}}, b}  : {{(XLEN-8){b[7]}}, b};
            2'b01:   return sz[2] ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // Replace the addressed byte/half of the read word with the store data.
    function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] w,
                                                    input logic [XLEN-1:0] d,
                                                    input logic [1:0]      off,
                                                    input logic [2:0]      sz);
        logic [XLEN-1:0] r;
        r = w;
        case (sz[1:0])
            2'b00:   r[{off, 3'b000} +: 8]     = d[7:0];
            2'b01:   r[{off[1], 4'b0000} +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    // size[1] set means a word access; 2'b00 byte, 2'b01 half.
    always_comb begin
        addr_d       = bus.ls_base + bus.ls_offset;
        misaligned_d = (bus.ls_size[1:0] == 2'b01 && addr_d[0]) ||
                       (bus.ls_size[1] && addr_d[1:0] != 2'b00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            word_q     <= '0;
            size_q     <= '0;
            is_store_q <= 1'b0;
            tag_q      <= '0;
            exc_q      <= 1'b0;
        end else if (bus.flush) begin
            // A write completing in this same cycle has reached the cache;
            // only its CDB result is dropped.
            state_q <= IDLE;
            exc_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ls_valid) begin
                        addr_q     <= addr_d;
                        data_q     <= bus.ls_store_data;
                        size_q     <= bus.ls_size;
                        is_store_q <= bus.ls_is_store;
                        tag_q      <= bus.ls_tag;
                        word_q     <= '0;
                        exc_q      <= misaligned_d;
                        if (misaligned_d)
                            state_q <= DONE;
                        else if (bus.ls_is_store && bus.ls_size[1])
                            state_q <= WR;
                        else
                            state_q <= RD;
                    end
                end
                RD: begin
                    if (bus.cache2proc_valid) begin
                        word_q <= bus.cache2proc_data;
                        if (is_store_q) begin
                            data_q  <= store_merge(bus.cache2proc_data, data_q,
                                                   addr_q[1:0], size_q);
                            state_q <= WR;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                WR: begin
                    if (bus.cache2proc_valid)
                        state_q <= DONE;
                end
                DONE: begin
                    if (bus.cdb_grant) begin
                        state_q <= IDLE;
                        exc_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ls_ready        = (state_q == IDLE);
    assign bus.cache_read      = (state_q == RD);
    assign bus.cache_write     = (state_q == WR);
    assign bus.proc2cache_addr = addr_q;
    assign bus.proc2cache_data = data_q;
    assign bus.proc2cache_size = 3'b010;
    assign bus.cdb_valid       = (state_q == DONE);
    assign bus.cdb_tag         = tag_q;
    assign bus.cdb_exc         = exc_q;
    assign bus.cdb_value       = (is_store_q || exc_q) ? '0
                                 : load_extract(word_q, addr_q[1:0], size_q);
    assign bus.state_dbg       = state_q;
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int EW    = TAG_W + 1 + XLEN;

    typedef struct {
        logic             is_store;
        logic [XLEN-1:0]  base;
        logic [XLEN-1:0]  off;
        logic [XLEN-1:0]  sdata;
        logic [2:0]       size;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  rd_word;
        int               rd_miss;
        int               wr_miss;
        int               grant_wait;
        logic [XLEN-1:0]  exp_addr;
        logic [XLEN-1:0]  exp_wdata;
        logic [XLEN-1:0]  exp_value;
        logic             exp_exc;
        int               exp_lat;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();

    load_store_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    vec_t vecs[16];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check helpers ----------------
    task automatic check_bit(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic check_word(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: unexpected DUT behaviour at %0t", nm, $time);
    endtask

    function automatic vec_t mk(input logic st, input logic [XLEN-1:0] base, input logic [XLEN-1:0] off,
                                input logic [XLEN-1:0] sdata, input logic [2:0] size, input logic [TAG_W-1:0] tag,
                                input logic [XLEN-1:0] rd_word, input int rd_miss, input int wr_miss,
                                input int grant_wait, input logic [XLEN-1:0] exp_addr,
                                input logic [XLEN-1:0] exp_wdata, input logic [XLEN-1:0] exp_value,
                                input logic exp_exc, input int exp_lat);
        vec_t v;
        v.is_store = st; v.base = base; v.off = off; v.sdata = sdata; v.size = size; v.tag = tag;
        v.rd_word = rd_word; v.rd_miss = rd_miss; v.wr_miss = wr_miss; v.grant_wait = grant_wait;
        v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_value = exp_value;
        v.exp_exc = exp_exc; v.exp_lat = exp_lat;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_op(input logic st, input logic [XLEN-1:0] base, input logic [XLEN-1:0] off,
                            input logic [XLEN-1:0] sdata, input logic [2:0] size, input logic [TAG_W-1:0] tag);
        bus.ls_valid      = 1'b1;
        bus.ls_is_store   = st;
        bus.ls_base       = base;
        bus.ls_offset     = off;
        bus.ls_store_data = sdata;
        bus.ls_size       = size;
        bus.ls_tag        = tag;
        @(negedge clk);
        bus.ls_valid      = 1'b0;
    endtask

    // Issues one op, plays the cache (with misses) and the CDB arbiter,
    // and compares every cycle until the result is retired.
    task automatic run_vec(input vec_t v, input string nm);
        int rmiss;
        int wmiss;
        bit done;
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        rmiss = v.rd_miss;
        wmiss = v.wr_miss;
        done  = 1'b0;
        check_bit({nm, " ready_before"}, bus.ls_ready, 1'b1);
        exp_q.push_back({v.tag, v.exp_exc, v.exp_value});
        drive_op(v.is_store, v.base, v.off, v.sdata, v.size, v.tag);
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            bus.cache2proc_valid = 1'b0;
            check_bit({nm, " ready_busy"}, bus.ls_ready, 1'b0);
            if (bus.cdb_valid) begin
                check_word({nm, " latency"}, XLEN'(cyc), XLEN'(v.exp_lat));
                check_bit({nm, " no_req_in_done"}, bus.cache_read | bus.cache_write, 1'b0);
                got = {bus.cdb_tag, bus.cdb_exc, bus.cdb_value};
                if (exp_q.size() == 0) begin
                    fail({nm, " cdb_without_expectation"});
                    e = got;
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (got !== e) begin
                        bad++;
                        $display("FAIL %s cdb: got tag=%0d exc=%b val=0x%08h want tag=%0d exc=%b val=0x%08h",
                                 nm, got[EW-1 -: TAG_W], got[XLEN], got[XLEN-1:0],
                                 e[EW-1 -: TAG_W], e[XLEN], e[XLEN-1:0]);
                    end
                end
                for (int g = 0; g < v.grant_wait; g++) begin
                    @(negedge clk);
                    check_bit({nm, " cdb_valid_hold"}, bus.cdb_valid, 1'b1);
                    got = {bus.cdb_tag, bus.cdb_exc, bus.cdb_value};
                    total++;
                    if (got !== e) begin
                        bad++;
                        $display("FAIL %s cdb_hold: got 0x%0h want 0x%0h", nm, got, e);
                    end
                end
                bus.cdb_grant = 1'b1;
                @(negedge clk);
                bus.cdb_grant = 1'b0;
                check_bit({nm, " ready_after"}, bus.ls_ready, 1'b1);
                check_bit({nm, " cdb_valid_after"}, bus.cdb_valid, 1'b0);
                check_bit({nm, " cdb_exc_after"}, bus.cdb_exc, 1'b0);
                done = 1'b1;
            end else if (bus.cache_read) begin
                if (v.exp_exc) fail({nm, " read_on_misaligned"});
                check_bit({nm, " rd_no_write"}, bus.cache_write, 1'b0);
                check_word({nm, " rd_addr"}, bus.proc2cache_addr, v.exp_addr);
                check_word({nm, " rd_size"}, XLEN'(bus.proc2cache_size), 32'd2);
                if (rmiss > 0) begin
                    rmiss--;
                end else begin
                    bus.cache2proc_valid = 1'b1;
                    bus.cache2proc_data  = v.rd_word;
                end
                @(negedge clk);
            end else if (bus.cache_write) begin
                if (!v.is_store || v.exp_exc) fail({nm, " write_not_expected"});
                check_word({nm, " wr_addr"}, bus.proc2cache_addr, v.exp_addr);
                check_word({nm, " wr_data"}, bus.proc2cache_data, v.exp_wdata);
                check_word({nm, " wr_size"}, XLEN'(bus.proc2cache_size), 32'd2);
                if (wmiss > 0) begin
                    wmiss--;
                end else begin
                    bus.cache2proc_valid = 1'b1;
                    bus.cache2proc_data  = $urandom;
                end
                @(negedge clk);
            end else begin
                fail({nm, " busy_without_request"});
                @(negedge clk);
            end
        end
        bus.cache2proc_valid = 1'b0;
        if (!done) begin
            fail({nm, " timeout"});
            exp_q.delete();
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.flush = 1'b0; bus.ls_valid = 1'b0; bus.ls_is_store = 1'b0;
        bus.ls_base = '0; bus.ls_offset = '0; bus.ls_store_data = '0;
        bus.ls_size = 3'b010; bus.ls_tag = '0;
        bus.cache2proc_data = '0; bus.cache2proc_valid = 1'b0; bus.cdb_grant = 1'b0;

        //          st    base          off           sdata         size    tag    rd_word       rm wm gw exp_addr      exp_wdata     exp_value     exc lat
        vecs[0]  = mk(1'b0, 32'h100,      32'h4,        32'h0,        3'b010, 5'd1,  32'hDEADBEEF, 0, 0, 0, 32'h104,      32'h0,        32'hDEADBEEF, 0, 2);
        vecs[1]  = mk(1'b0, 32'h100,      32'h3,        32'h0,        3'b000, 5'd2,  32'h80FF1234, 0, 0, 0, 32'h103,      32'h0,        32'hFFFFFF80, 0, 2);
        vecs[2]  = mk(1'b0, 32'h100,      32'h3,        32'h0,        3'b100, 5'd3,  32'h80FF1234, 0, 0, 1, 32'h103,      32'h0,        32'h00000080, 0, 2);
        vecs[3]  = mk(1'b0, 32'h100,      32'h2,        32'h0,        3'b001, 5'd4,  32'h80FF1234, 0, 0, 0, 32'h102,      32'h0,        32'hFFFF80FF, 0, 2);
        vecs[4]  = mk(1'b0, 32'h100,      32'h0,        32'h0,        3'b101, 5'd5,  32'h80FF1234, 0, 0, 0, 32'h100,      32'h0,        32'h00001234, 0, 2);
        vecs[5]  = mk(1'b1, 32'h100,      32'h1,        32'hAB,       3'b000, 5'd6,  32'h11223344, 0, 0, 0, 32'h101,      32'h1122AB44, 32'h0,        0, 3);
        vecs[6]  = mk(1'b1, 32'h100,      32'h2,        32'h5555BEEF, 3'b001, 5'd7,  32'h11223344, 0, 0, 0, 32'h102,      32'hBEEF3344, 32'h0,        0, 3);
        vecs[7]  = mk(1'b1, 32'h200,      32'hFFFFFFFC, 32'hCAFEF00D, 3'b010, 5'd8,  32'h0,        0, 3, 0, 32'h1FC,      32'hCAFEF00D, 32'h0,        0, 5);
        vecs[8]  = mk(1'b0, 32'h300,      32'h0,        32'h0,        3'b010, 5'd9,  32'h01234567, 5, 0, 0, 32'h300,      32'h0,        32'h01234567, 0, 7);
        vecs[9]  = mk(1'b0, 32'h100,      32'h2,        32'h0,        3'b010, 5'd10, 32'h0,        0, 0, 3, 32'h102,      32'h0,        32'h0,        1, 1);
        vecs[10] = mk(1'b0, 32'h100,      32'h1,        32'h0,        3'b001, 5'd11, 32'h0,        0, 0, 0, 32'h101,      32'h0,        32'h0,        1, 1);
        vecs[11] = mk(1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        3'b010, 5'd12, 32'hA5A5A5A5, 0, 0, 0, 32'h0,        32'h0,        32'hA5A5A5A5, 0, 2);
        vecs[12] = mk(1'b1, 32'h500,      32'h3,        32'h12345677, 3'b000, 5'd13, 32'h0,        2, 0, 0, 32'h503,      32'h77000000, 32'h0,        0, 5);
        vecs[13] = mk(1'b0, 32'h600,      32'h0,        32'h0,        3'b000, 5'd14, 32'h0000007F, 0, 0, 0, 32'h600,      32'h0,        32'h0000007F, 0, 2);
        vecs[14] = mk(1'b1, 32'h100,      32'h1,        32'h99,       3'b010, 5'd15, 32'h0,        0, 0, 0, 32'h101,      32'h0,        32'h0,        1, 1);
        vecs[15] = mk(1'b0, 32'h100,      32'h2,        32'h0,        3'b101, 5'd31, 32'hFFFF0001, 0, 0, 2, 32'h102,      32'h0,        32'h0000FFFF, 0, 2);

        // reset state
        repeat (3) @(negedge clk);
        check_bit("rst ls_ready", bus.ls_ready, 1'b1);
        check_bit("rst cache_read", bus.cache_read, 1'b0);
        check_bit("rst cache_write", bus.cache_write, 1'b0);
        check_bit("rst cdb_valid", bus.cdb_valid, 1'b0);
        check_bit("rst cdb_exc", bus.cdb_exc, 1'b0);
        check_word("rst addr", bus.proc2cache_addr, 32'h0);
        check_word("rst cdb_value", bus.cdb_value, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // flush while waiting in RD: back to idle, no result
        drive_op(1'b0, 32'h400, 32'h0, 32'h0, 3'b010, 5'd20);
        check_bit("flush_rd read_before", bus.cache_read, 1'b1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check_bit("flush_rd read_after", bus.cache_read, 1'b0);
        check_bit("flush_rd ready", bus.ls_ready, 1'b1);
        check_bit("flush_rd cdb_valid", bus.cdb_valid, 1'b0);
        @(negedge clk);
        check_bit("flush_rd cdb_valid_later", bus.cdb_valid, 1'b0);

        // flush coinciding with the cache ack in WR: no CDB output
        drive_op(1'b1, 32'h440, 32'h0, 32'h12121212, 3'b010, 5'd21);
        check_bit("flush_wr write_before", bus.cache_write, 1'b1);
        bus.flush = 1'b1;
        bus.cache2proc_valid = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.cache2proc_valid = 1'b0;
        check_bit("flush_wr cdb_valid", bus.cdb_valid, 1'b0);
        check_bit("flush_wr write_after", bus.cache_write, 1'b0);
        check_bit("flush_wr ready", bus.ls_ready, 1'b1);

        // flush overrides ls_valid in IDLE
        bus.flush = 1'b1;
        drive_op(1'b0, 32'h480, 32'h0, 32'h0, 3'b010, 5'd22);
        bus.flush = 1'b0;
        check_bit("flush_idle ready", bus.ls_ready, 1'b1);
        check_bit("flush_idle read", bus.cache_read, 1'b0);
        @(negedge clk);
        check_bit("flush_idle cdb_valid", bus.cdb_valid, 1'b0);
        check_bit("flush_idle read_later", bus.cache_read, 1'b0);

        // asynchronous reset in the middle of a write
        drive_op(1'b1, 32'h4C0, 32'h0, 32'h34343434, 3'b010, 5'd23);
        check_bit("rst_wr write_before", bus.cache_write, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_bit("rst_wr write_now", bus.cache_write, 1'b0);
        check_bit("rst_wr ready_now", bus.ls_ready, 1'b1);
        check_bit("rst_wr cdb_valid_now", bus.cdb_valid, 1'b0);
        check_word("rst_wr addr_now", bus.proc2cache_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // unit works normally after reset
        run_vec(vecs[0], "post_reset");
        run_vec(vecs[5], "post_reset_sb");

        if (exp_q.size() != 0) fail("scoreboard_leftover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
